relu_batch_ctrl: RTL and testbench



---
 rtl/relu_ctrl_pkg.sv | 22 ++
 rtl/relu_slot_timer.sv | 47 ++++
 rtl/relu_batch_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_relu_batch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/relu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// relu_ctrl_pkg
// Shared definitions for the ReLU batch scheduler slice: the controller state
// encoding and the default geometry (sample width, batch length, issue slot
// period and ReLU unit latency).
// No ports; imported by relu_slot_timer and relu_batch_ctrl.
// -----------------------------------------------------------------------------
package relu_ctrl_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int BATCH_LEN_DEF = 16;
    localparam int PERIOD_DEF    = 6;
    localparam int RELU_LAT_DEF  = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/relu_slot_timer.sv
// -----------------------------------------------------------------------------
// relu_slot_timer
// Issue-slot period counter. Counts 0..PERIOD-1 and wraps; the slot is open
// while the count sits at PERIOD-1. While hold is asserted the count freezes,
// which keeps an open slot open until the sample is actually taken.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   clr       in   synchronous clear of the count (used outside RUN)
//   hold      in   freeze the count for this cycle
//   slot_open out  count equals PERIOD-1
// -----------------------------------------------------------------------------
module relu_slot_timer
    import relu_ctrl_pkg::*;
#(
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic hold,
    output logic slot_open
);

    localparam int                CNT_W = (PERIOD > 2) ? $clog2(PERIOD) : 2;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_r;

    // Period counter: clear has priority over hold, hold over advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (hold) begin
            cnt_r <= cnt_r;
        end else if (cnt_r == LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign slot_open = (cnt_r == LAST);

endmodule

// File: rtl/relu_batch_ctrl.sv
// -----------------------------------------------------------------------------
// relu_batch_ctrl
// Batch scheduler in front of the ReLU datapath. Accepts BATCH_LEN signed
// samples over a valid/ready stream, issues one per PERIOD-cycle slot to the
// ReLU unit (relu_en pulse + relu_data), captures relu_result RELU_LAT cycles
// after the pulse and returns it on a valid/ready output stream.
// Optional feature macro: RELU_BATCH_CTRL_CLIPCNT_EN
//   defined   -> clip_cnt counts negative samples of the current/last batch
//   undefined -> clip_cnt is tied to zero, no counter is built
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    one-cycle pulse, begins a batch when idle
//   in_valid/in_data/in_ready    input sample stream
//   relu_en/relu_data        issue to the ReLU unit
//   relu_result              ReLU unit output
//   out_valid/out_data/out_ready result stream
//   busy                     high in RUN and DRAIN
//   done                     one-cycle pulse at batch end
//   clip_cnt                 negative-sample count
// -----------------------------------------------------------------------------
module relu_batch_ctrl
    import relu_ctrl_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BATCH_LEN = BATCH_LEN_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int RELU_LAT  = RELU_LAT_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           in_ready,
    output logic                           relu_en,
    output logic [DATA_W-1:0]              relu_data,
    input  logic [DATA_W-1:0]              relu_result,
    output logic                           out_valid,
    output logic [DATA_W-1:0]              out_data,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(BATCH_LEN+1)-1:0] clip_cnt
);

    localparam int ACC_W = $clog2(BATCH_LEN + 1);

    state_e              state_r;
    logic                busy_r;
    logic                done_r;
    logic [ACC_W-1:0]    acc_cnt_r;
    logic                relu_en_r;
    logic [DATA_W-1:0]   relu_data_r;
    logic [RELU_LAT-1:0] vld_pipe_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_data_r;

    logic                slot_open_s;
    logic                in_flight_s;
    logic                pipe_exit_s;
    logic                in_ready_s;
    logic                accept_s;
    logic                timer_clr_s;
    logic                timer_hold_s;

    relu_slot_timer #(
        .PERIOD    (PERIOD)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .clr       (timer_clr_s),
        .hold      (timer_hold_s),
        .slot_open (slot_open_s)
    );

    // Slot gating and accept. in_ready must see out_ready in the same cycle
    // so that draining the output register can free the slot immediately.
    always_comb begin
        in_flight_s  = |vld_pipe_r;
        pipe_exit_s  = vld_pipe_r[RELU_LAT-1];
        in_ready_s   = 1'b0;
        if ((state_r == RUN) && slot_open_s && !in_flight_s &&
            (!out_valid_r || out_ready)) begin
            in_ready_s = 1'b1;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s     = in_ready_s && in_valid;
        timer_clr_s  = (state_r != RUN);
        // An open slot that is not taken (blocked or no data) stays open.
        timer_hold_s = slot_open_s && !accept_s;
    end

    // Issue register: one-cycle enable and operand held until the next issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            relu_en_r   <= 1'b0;
            relu_data_r <= {DATA_W{1'b0}};
        end else begin
            relu_en_r <= accept_s;
            if (accept_s) begin
                relu_data_r <= in_data;
            end
        end
    end

    // In-flight tracker: the valid bit leaves the last stage exactly when
    // relu_result belongs to the issued sample.
    generate
        if (RELU_LAT == 1) begin : g_pipe_single
            // Single-stage tracker follows the issue pulse.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe_r <= 1'b0;
                end else begin
                    vld_pipe_r <= accept_s;
                end
            end
        end else begin : g_pipe_multi
            // Multi-stage tracker shifts the issue pulse RELU_LAT deep.
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_pipe_r <= {RELU_LAT{1'b0}};
                end else begin
                    vld_pipe_r <= {vld_pipe_r[RELU_LAT-2:0], accept_s};
                end
            end
        end
    endgenerate

    // Output register: a new capture wins over a simultaneous drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_W{1'b0}};
        end else if (pipe_exit_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= relu_result;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // Batch FSM with registered busy/done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            acc_cnt_r <= {ACC_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        acc_cnt_r <= {ACC_W{1'b0}};
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        acc_cnt_r <= acc_cnt_r + ACC_W'(1);
                        if (acc_cnt_r == ACC_W'(BATCH_LEN - 1)) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!in_flight_s && !out_valid_r) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef RELU_BATCH_CTRL_CLIPCNT_EN
    logic [ACC_W-1:0] clip_cnt_r;

    // Negative-sample counter: cleared on batch start, held after the batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip_cnt_r <= {ACC_W{1'b0}};
        end else if ((state_r == IDLE) && start) begin
            clip_cnt_r <= {ACC_W{1'b0}};
        end else if (accept_s && in_data[DATA_W-1]) begin
            clip_cnt_r <= clip_cnt_r + ACC_W'(1);
        end
    end

    assign clip_cnt = clip_cnt_r;
`else
    assign clip_cnt = {ACC_W{1'b0}};
`endif

    assign in_ready  = in_ready_s;
    assign relu_en   = relu_en_r;
    assign relu_data = relu_data_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_relu_batch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_relu_batch_ctrl
// Directed + randomized bench for relu_batch_ctrl (BATCH_LEN=4, PERIOD=6,
// RELU_LAT=1). Expected results come from a plain reference: each output is
// max(sample, 0) in input order, clip count is the number of negative samples.
// The ReLU unit model drives a valid result only while relu_en is high and
// drives a deliberately wrong value otherwise.
// -----------------------------------------------------------------------------
module tb_relu_batch_ctrl;

    localparam int DW  = 8;
    localparam int BL  = 4;
    localparam int PER = 6;
    localparam int LAT = 1;
    localparam int CW  = $clog2(BL + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          relu_en;
    logic [DW-1:0] relu_data;
    logic [DW-1:0] relu_result;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] clip_cnt;

    int cmp_cnt = 0;
    int mis_cnt = 0;
    int step_n  = 0;

    logic [7:0] batch[$];
    logic [7:0] src[$];
    logic [7:0] got[$];
    int         got_step[$];
    int         acc_cnt_tb;
    int         en_cnt;
    int         done_cnt;
    int         done_step;
    int         iv_mode;
    int         or_mode;
    logic       start_req;

    always #5 clk = ~clk;

    assign relu_result = relu_en ? (relu_data[DW-1] ? {DW{1'b0}} : relu_data) : ~relu_data;

    relu_batch_ctrl #(
        .DATA_W      (DW),
        .BATCH_LEN   (BL),
        .PERIOD      (PER),
        .RELU_LAT    (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .relu_en     (relu_en),
        .relu_data   (relu_data),
        .relu_result (relu_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .busy        (busy),
        .done        (done),
        .clip_cnt    (clip_cnt)
    );

    function automatic logic [7:0] relu_ref(input logic [7:0] x);
        return ($signed(x) > 0) ? x : 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            mis_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        got.delete();
        got_step.delete();
        acc_cnt_tb = 0;
        en_cnt     = 0;
        done_cnt   = 0;
        done_step  = -1;
    endtask

    task automatic fill_random();
        batch.delete();
        for (int i = 0; i < BL; i++) batch.push_back(8'($urandom_range(0, 255)));
    endtask

    // One clock cycle: drive at negedge, observe 1 time unit later.
    task automatic cycle();
        start = start_req;
        start_req = 1'b0;
        if (src.size() > 0) begin
            in_data  = src[0];
            in_valid = (iv_mode == 1) || (iv_mode == 2 && $urandom_range(0, 1) == 1);
        end else begin
            in_data  = 8'h00;
            in_valid = 1'b0;
        end
        out_ready = (or_mode == 1) || (or_mode == 2 && $urandom_range(0, 1) == 1);
        #1;
        if (in_valid && in_ready && !rst) begin
            void'(src.pop_front());
            acc_cnt_tb++;
        end
        if (out_valid && out_ready && !rst) begin
            got.push_back(out_data);
            got_step.push_back(step_n);
        end
        if (relu_en) en_cnt++;
        if (done) begin
            done_cnt++;
            done_step = step_n;
        end
        @(negedge clk);
        step_n++;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            cycle();
            k++;
        end
        check({tag, ":done_seen"}, 32'(done_cnt != 0), 32'(1));
    endtask

    task automatic check_results(input string tag);
        int exp_clip = 0;
        check({tag, ":count"}, 32'(got.size()), 32'(batch.size()));
        for (int i = 0; i < batch.size(); i++) begin
            if (i < got.size()) check($sformatf("%s:out%0d", tag, i), 32'(got[i]), 32'(relu_ref(batch[i])));
            if ($signed(batch[i]) < 0) exp_clip++;
        end
`ifndef RELU_BATCH_CTRL_CLIPCNT_EN
        exp_clip = 0;
`endif
        check({tag, ":clip"}, 32'(clip_cnt), 32'(exp_clip));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ":in_ready"},  32'(in_ready),  32'(0));
        check({tag, ":relu_en"},   32'(relu_en),   32'(0));
        check({tag, ":relu_data"}, 32'(relu_data), 32'(0));
        check({tag, ":out_valid"}, 32'(out_valid), 32'(0));
        check({tag, ":out_data"},  32'(out_data),  32'(0));
        check({tag, ":busy"},      32'(busy),      32'(0));
        check({tag, ":done"},      32'(done),      32'(0));
        check({tag, ":clip"},      32'(clip_cnt),  32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int k;
        int cnt_a;
        int cnt_b;
        logic [7:0] first;

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        start_req = 1'b0; iv_mode = 1; or_mode = 1;
        clear_logs();
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
        check_all_zero("reset");

        // start together with rst is ignored
        rst = 1'b1; start_req = 1'b1;
        cycle();
        rst = 1'b0;
        check("start_with_rst:busy", 32'(busy), 32'(0));
        cycle();
        check("start_with_rst:busy_after", 32'(busy), 32'(0));

        // Scenario 1: fixed data, no back-pressure
        clear_logs();
        batch = '{8'h9A, 8'h2E, 8'h80, 8'h7F};
        src = batch; iv_mode = 1; or_mode = 1;
        s = step_n; start_req = 1'b1;
        wait_done("s1", 300);
        check_results("s1");
        if (got_step.size() == BL) begin
            check("s1:first_latency", 32'(got_step[0] - s), 32'(PER + 1 + LAT));
            for (int i = 1; i < BL; i++) check($sformatf("s1:spacing%0d", i), 32'(got_step[i] - got_step[i-1]), 32'(PER));
            check("s1:done_step", 32'(done_step - got_step[BL-1]), 32'(2));
        end
        check("s1:relu_en_count", 32'(en_cnt), 32'(BL));
        for (int i = 0; i < 20; i++) cycle();
        check("s1:done_once", 32'(done_cnt), 32'(1));
        check("s1:busy_idle", 32'(busy), 32'(0));
        check("s1:clip_hold", 32'(clip_cnt), 32'(`ifdef RELU_BATCH_CTRL_CLIPCNT_EN 2 `else 0 `endif));

        // Scenario 2: output stalled 20 cycles after the first result
        clear_logs(); fill_random();
        src = batch; iv_mode = 1; or_mode = 0; start_req = 1'b1;
        k = 0;
        while (!out_valid && k < 100) begin cycle(); k++; end
        check("s2:first_valid", 32'(out_valid), 32'(1));
        first = out_data; cnt_a = en_cnt; cnt_b = 0; s = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (in_ready) cnt_b++;
            if (out_data !== first) s++;
        end
        check("s2:in_ready_low", 32'(cnt_b), 32'(0));
        check("s2:data_stable", 32'(s), 32'(0));
        check("s2:no_relu_en", 32'(en_cnt - cnt_a), 32'(0));
        or_mode = 1;
        wait_done("s2", 300);
        check_results("s2");

        // Scenario 3: in_valid withheld at an open slot
        clear_logs(); fill_random();
        src = batch; iv_mode = 0; or_mode = 1; start_req = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin cycle(); k++; end
        check("s3:slot_open", 32'(in_ready), 32'(1));
        cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (in_ready) cnt_b++;
        end
        check("s3:slot_held", 32'(cnt_b), 32'(10));
        iv_mode = 1;
        cycle();
        check("s3:first_cycle_accept", 32'(acc_cnt_tb), 32'(1));
        wait_done("s3", 300);
        check_results("s3");

        // Scenario 4: reset two samples into a batch, then a full random batch
        clear_logs(); fill_random();
        src = batch; iv_mode = 1; or_mode = 1; start_req = 1'b1;
        k = 0;
        while (acc_cnt_tb < 2 && k < 100) begin cycle(); k++; end
        check("s4:two_accepted", 32'(acc_cnt_tb), 32'(2));
        rst = 1'b1; iv_mode = 0;
        cycle();
        rst = 1'b0;
        check_all_zero("s4_rst");
        for (int i = 0; i < 30; i++) cycle();
        check("s4:no_done", 32'(done_cnt), 32'(0));
        clear_logs(); fill_random();
        src = batch; iv_mode = 2; or_mode = 2; start_req = 1'b1;
        wait_done("s4", 3000);
        check_results("s4");

        // Scenario 5: spurious start pulses during the batch
        clear_logs(); fill_random();
        src = batch; iv_mode = 1; or_mode = 2; start_req = 1'b1;
        cycle();
        k = 0;
        while (done_cnt == 0 && k < 3000) begin
            start_req = ($urandom_range(0, 3) == 0);
            cycle();
            k++;
        end
        check("s5:done_seen", 32'(done_cnt), 32'(1));
        check_results("s5");
        for (int i = 0; i < 40; i++) cycle();
        check("s5:single_done", 32'(done_cnt), 32'(1));
        check("s5:no_extra_out", 32'(got.size()), 32'(BL));
        check("s5:busy_idle", 32'(busy), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
        $finish;
    end

endmodule
